lsu_handshake: RTL and testbench

- Multi-cycle load/store unit between the EXU (effective address, store data, access size) and the data memory.
- Replaces the core's single-cycle combinational memory access with a valid/ready request/response protocol, so memory can take an arbitrary number of cycles.
- Performs byte-lane steering, write-strobe generation, load sign/zero extension and misalignment detection.
- Returns load data to the register-file writeback path.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/lsu_handshake.sv | 166 ++++++++++++++++
 tb/tb_lsu_handshake.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access sizes,
// strobe constant and the misalignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_e;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} lsu_size_e;

  localparam logic [3:0] STRB_ALL = 4'b1111;

  // Size 3 is reserved and behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    if (size == SZ_B) begin
      mis = 1'b0;
    end else if (size == SZ_H) begin
      mis = addr_lo[0];
    end else begin
      mis = |addr_lo;
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data replication and strobes, load
// lane extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  assign byte_sh = rdata_i >> {addr_lo_i, 3'b000};
  assign half_sh = rdata_i >> {addr_lo_i[1], 4'b0000};

  always_comb begin
    wdata_o = wdata_i;
    wstrb_o = STRB_ALL;
    rdata_o = rdata_i;
    if (size_i == SZ_B) begin
      wdata_o = {4{wdata_i[7:0]}};
      wstrb_o = 4'b0001 << addr_lo_i;
      rdata_o = {{24{~uns_i & byte_sh[7]}}, byte_sh[7:0]};
    end else if (size_i == SZ_H) begin
      wdata_o = {2{wdata_i[15:0]}};
      wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      rdata_o = {{16{~uns_i & half_sh[15]}}, half_sh[15:0]};
    end
    // Loads never write a lane.
    if (!we_i) begin
      wstrb_o = 4'b0000;
    end
  end

endmodule

// File: rtl/lsu_handshake.sv
// Multi-cycle load/store unit with valid/ready request, memory and response sides.
// Optional LSU_PERF_CNT_EN adds load/store/stall performance counters.
module lsu_handshake
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]   perf_loads,
  output logic [31:0]   perf_stores,
  output logic [31:0]   perf_stall
`endif
);

  lsu_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] ext_rdata;
  logic [DW-1:0] load_data;
  logic          mis;

  lsu_lane_align u_align (
    .we_i      (we_q),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .wdata_o   (mem_wdata),
    .wstrb_o   (mem_wstrb),
    .rdata_o   (ext_rdata)
  );

  assign mis       = is_misaligned(req_size, req_addr[1:0]);
  assign load_data = we_q ? '0 : ext_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = mis;
          state_d = mis ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        // Completion may coincide with acceptance on a zero-wait memory.
        if (mem_ready) begin
          if (mem_rvalid) begin
            rdata_d = load_data;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign mem_valid = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] loads_q, stores_q, stall_q;
  logic        done;

  assign done = (state_q == RESP) && rsp_ready && !err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      stall_q  <= '0;
    end else begin
      if (done && !we_q) loads_q <= loads_q + 32'd1;
      if (done && we_q) stores_q <= stores_q + 32'd1;
      if ((state_q == ISSUE) || (state_q == WAIT)) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed and randomized checks of lsu_handshake against a byte-level memory
// reference model; memory and writeback sides are driven cycle by cycle.
module tb_lsu_handshake;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_stall;
  int          m_loads = 0, m_stores = 0, m_stall = 0;
`endif

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] dut_mem [16];
  logic [7:0]  ref_mem [64];

  lsu_handshake #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef LSU_PERF_CNT_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall(perf_stall)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed little-endian memory, spec rules only
  task automatic set_word(input int idx, input logic [31:0] val);
    dut_mem[idx] = val;
    for (int k = 0; k < 4; k++) ref_mem[4*idx+k] = val[8*k +: 8];
  endtask

  function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int          o;
    logic [15:0] h;
    logic [7:0]  b;
    o = int'(a[5:0]);
    if (sz == 2'd0) begin
      b = ref_mem[o];
      return (!u && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
    end
    if (sz == 2'd1) begin
      h = {ref_mem[o+1], ref_mem[o]};
      return (!u && h[15]) ? {16'hFFFF, h} : {16'h0, h};
    end
    return {ref_mem[o+3], ref_mem[o+2], ref_mem[o+1], ref_mem[o]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int o;
    int n;
    o = int'(a[5:0]);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[o+k] = wd[8*k +: 8];
  endtask

  // Driver: one complete access with chosen memory/writeback stalls
  task automatic do_access(input logic we, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int rdy_dly, input int rv_dly, input int rsp_dly);
    logic        mis;
    logic [31:0] exp_wdata, exp_rsp, cap_wdata, cap_addr;
    logic [3:0]  exp_strb, cap_strb;
    logic        cap_we;
    mis = ref_mis(a, sz);
    cap_wdata = '0; cap_addr = '0; cap_strb = '0; cap_we = 1'b0;
    if (sz == 2'd0) begin
      exp_wdata = {4{wd[7:0]}};
      exp_strb  = 4'b0001 << a[1:0];
    end else if (sz == 2'd1) begin
      exp_wdata = {2{wd[15:0]}};
      exp_strb  = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      exp_wdata = wd;
      exp_strb  = 4'b1111;
    end
    if (!we) exp_strb = 4'b0000;
    if (mis || we) exp_q.push_back(32'h0);
    else exp_q.push_back(ref_load(a, sz, u));
    if (!mis && we) ref_store(a, sz, wd);
`ifdef LSU_PERF_CNT_EN
    if (!mis && we) m_stores++;
    if (!mis && !we) m_loads++;
    if (!mis) m_stall += rdy_dly + 1 + rv_dly;
`endif

    check("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    req_wdata = $urandom;

    if (mis) begin
      check("mis_no_mem_valid", 32'(mem_valid), 32'h0);
      check("mis_rsp_err", 32'(rsp_err), 32'h1);
    end else begin
      check("issue_rsp_valid", 32'(rsp_valid), 32'h0);
      for (int i = 0; i <= rdy_dly; i++) begin
        check("issue_mem_valid", 32'(mem_valid), 32'h1);
        check("issue_mem_addr", mem_addr, {a[31:2], 2'b00});
        check("issue_mem_we", 32'(mem_we), 32'(we));
        check("issue_mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
        if (we) check("issue_mem_wdata", mem_wdata, exp_wdata);
        check("issue_req_ready", 32'(req_ready), 32'h0);
        if (i == rdy_dly) begin
          cap_wdata = mem_wdata; cap_addr = mem_addr; cap_strb = mem_wstrb; cap_we = mem_we;
          mem_ready = 1'b1;
          if (rv_dly == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = dut_mem[cap_addr[5:2]];
          end
        end
        tick();
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (cap_we) begin
        for (int k = 0; k < 4; k++)
          if (cap_strb[k]) dut_mem[cap_addr[5:2]][8*k +: 8] = cap_wdata[8*k +: 8];
      end
      for (int i = 0; i < rv_dly; i++) begin
        check("wait_mem_valid", 32'(mem_valid), 32'h0);
        check("wait_rsp_valid", 32'(rsp_valid), 32'h0);
        if (i == rv_dly - 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = dut_mem[cap_addr[5:2]];
        end
        tick();
      end
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end

    exp_rsp = exp_q.pop_front();
    for (int i = 0; i <= rsp_dly; i++) begin
      check("resp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("resp_rsp_rdata", rsp_rdata, exp_rsp);
      check("resp_rsp_err", 32'(rsp_err), 32'(mis));
      check("resp_req_ready", 32'(req_ready), 32'h0);
      if (i == rsp_dly) begin
        rsp_ready = 1'b1;
        // A request raised during the response handshake must not be taken.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0000;
      end
      tick();
    end
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'h0);
    check("post_not_accepted", 32'(mem_valid), 32'h0);
    check("post_req_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b0;
  endtask

  initial begin
    for (int w = 0; w < 16; w++) set_word(w, $urandom);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b1;
    tick();

    // Directed cases
    do_access(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00A5, 0, 0, 0);
    set_word(0, 32'h8001_1234);
    do_access(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 0, 0, 0);
    do_access(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 0, 0, 0);
    do_access(1'b0, 2'd2, 1'b0, 32'h8000_0006, 32'h0, 0, 0, 0);
    do_access(1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 3, 2, 2);
    do_access(1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'h1234_BEEF, 3, 2, 2);
    do_access(1'b0, 2'd3, 1'b0, 32'h8000_0010, 32'h0, 1, 1, 0);

    // Completion strobe while idle is ignored
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("idle_rvalid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("idle_rvalid_req_ready", 32'(req_ready), 32'h1);

    // Reset while waiting for memory completion
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0020;
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("wait_pre_rst_req_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("midrst_mem_valid", 32'(mem_valid), 32'h0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    tick();
`ifdef LSU_PERF_CNT_EN
    m_loads = 0; m_stores = 0; m_stall = 0;
    check("midrst_perf_loads", perf_loads, 32'h0);
    check("midrst_perf_stores", perf_stores, 32'h0);
    check("midrst_perf_stall", perf_stall, 32'h0);
`endif
    do_access(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 0, 0, 0);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'h8000_0000 | 32'($urandom_range(0, 63)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

`ifdef LSU_PERF_CNT_EN
    check("perf_loads", perf_loads, 32'(m_loads));
    check("perf_stores", perf_stores, 32'(m_stores));
    check("perf_stall", perf_stall, 32'(m_stall));
`endif

    // Report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
